seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the clk cycles per digit slot (minimum 2).
REQ-002 Parameter BLINK_FRAMES, default 62, SHALL set the scan frames per separator blink half-period (minimum 1).
REQ-003 clk  input  1  SHALL be the single system clock; all state is on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 hexs  input  24  SHALL carry packed BCD time HH:MM:SS: [23:20] hour tens, [19:16] hour units, [15:12] minute tens, [11:8] minute units, [7:4] second tens, [3:0] second units.
REQ-006 blank_lz  input  1  SHALL, when 1, blank the hour-tens digit while its snapshot value is 0.
REQ-007 sep_blink  input  1  SHALL, when 1, make the two separator dashes blink; when 0 they are steady on.
REQ-008 an  output  8  SHALL be the active-low digit enables; bit 7 is the leftmost digit.
REQ-009 seg  output  8  SHALL be the active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 frame  output  1  SHALL pulse high for exactly one clk cycle at each frame start.

Function
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; its terminal count is the slot tick.
REQ-012 The 3-bit slot index idx SHALL increment on every slot tick and wrap from 7 to 0.
REQ-013 On the slot tick where idx wraps 7->0, a 24-bit snapshot SHALL capture hexs and frame SHALL be asserted for that single cycle.
REQ-014 All digits SHALL be rendered from the snapshot only, so hexs changes mid-frame have no visible effect until the next frame start.
REQ-015 Slot map: idx 7 = hour tens, 6 = hour units, 5 = dash, 4 = minute tens, 3 = minute units, 2 = dash, 1 = second tens, 0 = second units.
REQ-016 an and seg SHALL be registered and SHALL reflect a new idx one clk cycle after idx changes (latency 1).
REQ-017 an SHALL have exactly the bit of the displayed idx low and all other bits high.
REQ-018 Digit encodings (hex, active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
REQ-019 A nibble value of A..F SHALL display as E (86).
REQ-020 The dash glyph SHALL be BF, the blank glyph SHALL be FF, and dp SHALL always be 1.
REQ-021 Leading-zero blanking: when blank_lz=1 and snapshot[23:20]=0, slot 7 SHALL output seg=FF with its an bit still low.
REQ-022 A frame counter SHALL count 0..BLINK_FRAMES-1 on frame pulses; on its wrap, blink phase bp SHALL toggle.
REQ-023 Dash slots SHALL show BF when sep_blink=0 or bp=1, and FF when sep_blink=1 and bp=0.
REQ-024 Slot tick, frame start and a hexs change in the same cycle SHALL capture the hexs value present on that edge.

Reset
REQ-025 While rst=0, the block SHALL asynchronously force: prescaler=0, idx=0, snapshot=000000, frame counter=0, bp=0, an=FF, seg=FF, frame=0.
REQ-026 After rst deasserts, the first an/seg update SHALL occur one cycle after the first slot tick.
REQ-027 Until the first frame start, all digits SHALL render from snapshot 000000.
REQ-028 Reset asserted mid-frame SHALL abort the scan immediately, with no partial frame pulse.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-029 Scenario: hexs=235959, blank_lz=0, sep_blink=0; run 2 frames. Required: second frame scans an=FE,FD,FB,F7,EF,DF,BF,7F with seg=90,92,BF,90,92,BF,B0,A4.
REQ-030 Scenario: hexs=075900, blank_lz=1. Required: slot 7 gives an=7F, seg=FF.
REQ-031 Scenario: repeat REQ-030 with blank_lz=0. Required: slot 7 gives seg=C0.
REQ-032 Scenario: change hexs mid-frame from 120000 to 120001. Required: slot 0 shows C0 until the next frame pulse, then F9.
REQ-033 Scenario: hexs=0A0000. Required: slot 6 shows seg=86.
REQ-034 Scenario: sep_blink=1; run 6 frames. Required: dash slots give FF for frames 1-2, BF for frames 3-4, FF for frames 5-6; frame pulse width is 1 cycle every 32 cycles.
REQ-035 Scenario: pulse rst low for 1 cycle mid-slot-3. Required: an=FF and seg=FF immediately and all counters at 0; the rebuild of an/seg starts from slot 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit seven-segment driver for an HH-MM-SS clock face.
// A per-frame snapshot of the packed BCD time is rendered one digit slot at a time.
module seg_scan_display #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] hexs,
  input  logic        blank_lz,
  input  logic        sep_blink,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_ERR   = 8'h86;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q,   idx_d;
  logic [23:0]   snap_q,  snap_d;
  logic [FW-1:0] fcnt_q,  fcnt_d;
  logic          bp_q,    bp_d;
  logic          run_q,   run_d;
  logic [7:0]    an_q,    an_d;
  logic [7:0]    seg_q,   seg_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic          is_dash;
  logic [7:0]    glyph;

  function automatic logic [7:0] encode_digit(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = GLYPH_ERR;
    endcase
    return g;
  endfunction

  // Digit selection and glyph rendering from the frame snapshot.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    nib     = 4'd0;
    is_dash = 1'b0;
    case (idx_q)
      3'd7:    nib = snap_q[23:20];
      3'd6:    nib = snap_q[19:16];
      3'd4:    nib = snap_q[15:12];
      3'd3:    nib = snap_q[11:8];
      3'd1:    nib = snap_q[7:4];
      3'd0:    nib = snap_q[3:0];
      default: is_dash = 1'b1;
    endcase

    if (is_dash) begin
      glyph = (!sep_blink || bp_q) ? GLYPH_DASH : GLYPH_BLANK;
    end else if (idx_q == 3'd7 && blank_lz && nib == 4'd0) begin
      glyph = GLYPH_BLANK;
    end else begin
      glyph = encode_digit(nib);
    end
  end

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    wrap    = tick && (idx_q == 3'd7);

    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    snap_d  = wrap ? hexs : snap_q;
    frame_d = wrap;
    run_d   = run_q | tick;

    fcnt_d  = fcnt_q;
    bp_d    = bp_q;
    if (wrap) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d = '0;
        bp_d   = ~bp_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // The outputs stay dark after reset until the first slot tick has happened.
    an_d  = an_q;
    seg_d = seg_q;
    if (run_q) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = glyph;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      snap_q  <= 24'h000000;
      fcnt_q  <= '0;
      bp_q    <= 1'b0;
      run_q   <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      fcnt_q  <= fcnt_d;
      bp_q    <= bp_d;
      run_q   <= run_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with SCAN_DIV=4, BLINK_FRAMES=2.
// Timing is counted in falling edges after reset release; slot s of frame f is sampled mid-slot.
module tb_seg_scan_display;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] hexs = 24'h0;
  logic        blank_lz = 1'b0;
  logic        sep_blink = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  seg_scan_display #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hexs     (hexs),
    .blank_lz (blank_lz),
    .sep_blink(sep_blink),
    .an       (an),
    .seg      (seg),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Holds reset across two rising edges, checks the reset state, releases on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, " rst an"}, an, 8'hFF);
    check({tag, " rst seg"}, seg, 8'hFF);
    check({tag, " rst frame"}, 8'(frame), 8'h00);
    rst = 1'b1;
    cyc = 0;
  endtask

  // Frame 1 is the scan that begins at reset release; slot s shows after edge 32(f-1)+4s+1.
  task automatic check_slot(input string tag, input int f, input int s,
                            input logic [7:0] exp_an, input logic [7:0] exp_seg);
    run_to(FRAME_LEN * (f - 1) + SCAN_DIV * s + 2);
    check($sformatf("%s f%0d s%0d an", tag, f, s), an, exp_an);
    check($sformatf("%s f%0d s%0d seg", tag, f, s), seg, exp_seg);
  endtask

  logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_2359 [8] = '{8'h90, 8'h92, 8'hBF, 8'h90, 8'h92, 8'hBF, 8'hB0, 8'hA4};
  logic [7:0] seg_3456 [8] = '{8'h80, 8'hF8, 8'hBF, 8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0};

  initial begin
    int pulses;
    int misplaced;
    logic [7:0] dash_exp;

    // Full scan of 23-59-59, steady separators.
    hexs = 24'h235959; blank_lz = 1'b0; sep_blink = 1'b0;
    do_reset("full");
    run_to(4);
    check("full dark before first tick an", an, 8'hFF);
    check_slot("full pre-snapshot", 1, 6, 8'hBF, 8'hC0);
    check_slot("full pre-snapshot", 1, 7, 8'h7F, 8'hC0);
    run_to(FRAME_LEN - 1);
    check("full frame before start", 8'(frame), 8'h00);
    run_to(FRAME_LEN);
    check("full frame at start", 8'(frame), 8'h01);
    run_to(FRAME_LEN + 1);
    check("full frame one cycle wide", 8'(frame), 8'h00);
    for (int s = 0; s < 8; s++) check_slot("full", 2, s, an_tab[s], seg_2359[s]);

    // Leading-zero blanking of the hour tens, then the same digit unblanked.
    hexs = 24'h075900; blank_lz = 1'b1;
    do_reset("lz");
    check_slot("lz on", 2, 6, 8'hBF, 8'hF8);
    check_slot("lz on", 2, 7, 8'h7F, 8'hFF);
    blank_lz = 1'b0;
    check_slot("lz off", 3, 7, 8'h7F, 8'hC0);

    // Mid-frame input change stays hidden until the next frame start.
    hexs = 24'h120000;
    do_reset("snap");
    check_slot("snap old", 2, 0, 8'hFE, 8'hC0);
    run_to(FRAME_LEN + 8);
    hexs = 24'h120001;
    check_slot("snap held", 2, 7, 8'h7F, 8'hF9);
    run_to(2 * FRAME_LEN);
    check("snap frame pulse", 8'(frame), 8'h01);
    check_slot("snap new", 3, 0, 8'hFE, 8'hF9);

    // Non-decimal nibble, with hexs changed in the same cycle as the frame-start edge.
    hexs = 24'h000000;
    do_reset("hex");
    run_to(FRAME_LEN - 1);
    hexs = 24'h0A0000;
    check_slot("hex", 2, 6, 8'hBF, 8'h86);
    check_slot("hex", 2, 7, 8'h7F, 8'hC0);

    // Remaining digit encodings, then all-invalid nibbles with a nonzero hour tens.
    hexs = 24'h345678;
    do_reset("enc");
    for (int s = 0; s < 8; s++) check_slot("enc", 2, s, an_tab[s], seg_3456[s]);
    hexs = 24'hFBCDEF; blank_lz = 1'b1;
    check_slot("enc err", 3, 0, 8'hFE, 8'h86);
    check_slot("enc err", 3, 4, 8'hEF, 8'h86);
    check_slot("enc err", 3, 7, 8'h7F, 8'h86);

    // Separator blink over six frames plus frame pulse placement.
    hexs = 24'h000000; blank_lz = 1'b0; sep_blink = 1'b1;
    do_reset("blink");
    pulses    = 0;
    misplaced = 0;
    for (int n = 1; n <= 6 * FRAME_LEN; n++) begin
      int f;
      step();
      f = (n - 1) / FRAME_LEN + 1;
      if (frame) begin
        pulses++;
        if (n % FRAME_LEN != 0) misplaced++;
      end
      dash_exp = (f == 3 || f == 4) ? 8'hBF : 8'hFF;
      if (n % FRAME_LEN == SCAN_DIV * 2 + 2) begin
        check($sformatf("blink f%0d s2 an", f), an, 8'hFB);
        check($sformatf("blink f%0d s2 seg", f), seg, dash_exp);
      end
      if (n % FRAME_LEN == SCAN_DIV * 5 + 2) begin
        check($sformatf("blink f%0d s5 seg", f), seg, dash_exp);
      end
    end
    check("blink pulse count", 8'(pulses), 8'd6);
    check("blink misplaced pulses", 8'(misplaced), 8'd0);

    // Short asynchronous reset in the middle of slot 3.
    hexs = 24'h235959; blank_lz = 1'b0; sep_blink = 1'b0;
    do_reset("abort");
    check_slot("abort pre", 2, 3, 8'hF7, 8'h90);
    #1 rst = 1'b0;
    #1;
    check("abort async an", an, 8'hFF);
    check("abort async seg", seg, 8'hFF);
    check("abort async frame", 8'(frame), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run_to(4);
    check("abort dark an", an, 8'hFF);
    check("abort dark seg", seg, 8'hFF);
    check_slot("abort snapshot cleared", 1, 7, 8'h7F, 8'hC0);
    run_to(FRAME_LEN - 1);
    check("abort no early frame", 8'(frame), 8'h00);
    run_to(FRAME_LEN);
    check("abort first frame", 8'(frame), 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
